// File: rtl/fir_coef_bank_if.sv
// Host-side configuration bus for the FIR coefficient bank.
// A word transfers on any rising clk edge where cfg_valid && cfg_ready are both high.
interface fir_coef_bank_if #(
   parameter int COEF_W = 8,
   parameter int IDX_W  = 4
);
   logic              cfg_start;
   logic [IDX_W-1:0]  cfg_len;
   logic              cfg_valid;
   logic [COEF_W-1:0] cfg_data;
   logic              cfg_ready;
   logic              cfg_abort;

   modport master (
      output cfg_start, cfg_len, cfg_valid, cfg_data, cfg_abort,
      input  cfg_ready
   );

   modport slave (
      input  cfg_start, cfg_len, cfg_valid, cfg_data, cfg_abort,
      output cfg_ready
   );
endinterface

// File: rtl/fir_coef_bank.sv
// Double-buffered FIR coefficient store: loads stream into a shadow bank and
// are committed atomically to the active bank at a filter-safe boundary.
module fir_coef_bank #(
   parameter int                COEF_W     = 8,
   parameter int                MAX_TAPS   = 16,
   parameter int                IDX_W      = $clog2(MAX_TAPS),
   parameter logic [COEF_W-1:0] RESET_COEF = 8'h40
) (
   input  logic                       clk,
   input  logic                       rst_n,
   fir_coef_bank_if.slave             cfg,
   input  logic                       swap_ok,
   output logic [MAX_TAPS*COEF_W-1:0] coef_flat,
   output logic [IDX_W-1:0]           tap_num,
   output logic                       cfg_busy,
   output logic                       cfg_done,
   output logic                       cfg_err,
   output logic [1:0]                 dbg_state
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_SWAP = 2'd2
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  wr_ptr;
   logic [IDX_W-1:0]  len_q;
   logic [COEF_W-1:0] shadow [MAX_TAPS];

   assign cfg.cfg_ready = (state == LOAD);
   assign cfg_busy      = (state != IDLE);
   assign dbg_state     = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         len_q     <= '0;
         coef_flat <= {MAX_TAPS{RESET_COEF}};
         tap_num   <= IDX_W'(MAX_TAPS - 1);
         cfg_done  <= 1'b0;
         cfg_err   <= 1'b0;
         for (int i = 0; i < MAX_TAPS; i++) shadow[i] <= '0;
      end else begin
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg.cfg_start) begin
                  state  <= LOAD;
                  len_q  <= cfg.cfg_len;
                  wr_ptr <= '0;
                  for (int i = 0; i < MAX_TAPS; i++) shadow[i] <= '0;
               end
            end
            LOAD: begin
               // Abort takes priority over any write or restart in the same cycle.
               if (cfg.cfg_abort) begin
                  state   <= IDLE;
                  cfg_err <= 1'b1;
               end else begin
                  if (cfg.cfg_start) cfg_err <= 1'b1;
                  if (cfg.cfg_valid) begin
                     shadow[wr_ptr] <= cfg.cfg_data;
                     if (wr_ptr == len_q) state <= WAIT_SWAP;
                     else wr_ptr <= wr_ptr + 1'b1;
                  end
               end
            end
            WAIT_SWAP: begin
               if (cfg.cfg_abort) begin
                  state   <= IDLE;
                  cfg_err <= 1'b1;
               end else begin
                  if (cfg.cfg_start) cfg_err <= 1'b1;
                  if (swap_ok) begin
                     for (int i = 0; i < MAX_TAPS; i++)
                        coef_flat[i*COEF_W +: COEF_W] <= shadow[i];
                     tap_num  <= len_q;
                     cfg_done <= 1'b1;
                     state    <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_coef_bank.sv
// Directed bench for fir_coef_bank: session-level reference model compared
// every cycle, plus hand-computed bank snapshots.
module tb_fir_coef_bank;
   localparam int COEF_W   = 8;
   localparam int MAX_TAPS = 16;
   localparam int IDX_W    = 4;
   localparam int FLAT_W   = MAX_TAPS * COEF_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              swap_ok = 1'b0;
   logic [FLAT_W-1:0] coef_flat;
   logic [IDX_W-1:0]  tap_num;
   logic              cfg_busy, cfg_done, cfg_err;
   logic [1:0]        dbg_state;

   int checks = 0;
   int errors = 0;
   bit run_cmp = 1'b0;

   fir_coef_bank_if #(.COEF_W(COEF_W), .IDX_W(IDX_W)) cfg_if ();

   fir_coef_bank dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg       (cfg_if),
      .swap_ok   (swap_ok),
      .coef_flat (coef_flat),
      .tap_num   (tap_num),
      .cfg_busy  (cfg_busy),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [FLAT_W-1:0] act, input logic [FLAT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a session is either collecting words or waiting to commit.
   logic [COEF_W-1:0] m_active [MAX_TAPS];
   logic [IDX_W-1:0]  m_tap;
   logic [IDX_W-1:0]  m_len;
   logic [COEF_W-1:0] exp_q [$];
   bit                m_in, m_wait, m_done, m_err;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         for (int i = 0; i < MAX_TAPS; i++) m_active[i] = 8'h40;
         m_tap = IDX_W'(MAX_TAPS - 1);
         m_len = '0;
         m_in = 0; m_wait = 0; m_done = 0; m_err = 0;
         exp_q.delete();
      end else begin
         m_done = 0;
         m_err  = 0;
         if (!m_in) begin
            if (cfg_if.cfg_start) begin
               m_in = 1; m_wait = 0; m_len = cfg_if.cfg_len;
               exp_q.delete();
            end
         end else if (cfg_if.cfg_abort) begin
            m_in = 0;
            m_err = 1;
         end else begin
            if (cfg_if.cfg_start) m_err = 1;
            if (!m_wait) begin
               if (cfg_if.cfg_valid) begin
                  exp_q.push_back(cfg_if.cfg_data);
                  if (exp_q.size() == int'(m_len) + 1) m_wait = 1;
               end
            end else if (swap_ok) begin
               for (int i = 0; i < MAX_TAPS; i++)
                  m_active[i] = (i < exp_q.size()) ? exp_q[i] : '0;
               m_tap = m_len;
               m_done = 1;
               m_in = 0;
            end
         end
      end
   end

   function automatic logic [FLAT_W-1:0] model_flat();
      logic [FLAT_W-1:0] f;
      for (int i = 0; i < MAX_TAPS; i++) f[i*COEF_W +: COEF_W] = m_active[i];
      return f;
   endfunction

   initial forever begin
      @(negedge clk);
      if (run_cmp) begin
         check("coef_flat", coef_flat, model_flat());
         check("tap_num", FLAT_W'(tap_num), FLAT_W'(m_tap));
         check("cfg_busy", FLAT_W'(cfg_busy), FLAT_W'(m_in));
         check("cfg_ready", FLAT_W'(cfg_if.cfg_ready), FLAT_W'(m_in && !m_wait));
         check("cfg_done", FLAT_W'(cfg_done), FLAT_W'(m_done));
         check("cfg_err", FLAT_W'(cfg_err), FLAT_W'(m_err));
      end
   end

   task automatic step(input logic s, input logic [IDX_W-1:0] l, input logic v,
                       input logic [COEF_W-1:0] d, input logic a, input logic sw);
      cfg_if.cfg_start = s;
      cfg_if.cfg_len   = l;
      cfg_if.cfg_valid = v;
      cfg_if.cfg_data  = d;
      cfg_if.cfg_abort = a;
      swap_ok          = sw;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic word(input logic [COEF_W-1:0] d);
      step(0, 0, 1, d, 0, 0);
   endtask

   logic [FLAT_W-1:0] reset_bank;
   logic [FLAT_W-1:0] bank_a;
   logic [FLAT_W-1:0] bank_b;

   initial begin
      reset_bank = {MAX_TAPS{8'h40}};
      bank_a = 128'h0000_0000_0000_0000_0000_0000_4433_2211;
      bank_b = 128'h0000_0000_0000_0000_0000_0000_0000_6655;
      cfg_if.cfg_start = 0; cfg_if.cfg_len = 0; cfg_if.cfg_valid = 0;
      cfg_if.cfg_data = 0; cfg_if.cfg_abort = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_cmp = 1'b1;

      // Reset state, then stray valid/abort in IDLE
      idle(2);
      check("t1_coef", coef_flat, reset_bank);
      check("t1_tap", FLAT_W'(tap_num), FLAT_W'(15));
      check("t1_busy", FLAT_W'(cfg_busy), '0);
      check("t1_ready", FLAT_W'(cfg_if.cfg_ready), '0);
      step(0, 0, 1, 8'h5A, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      check("t1_idle_err", FLAT_W'(cfg_err), '0);

      // 4-tap load with gaps, held swap, then commit
      step(1, 4'd3, 0, 0, 0, 0);
      word(8'h11); idle(1); word(8'h22); word(8'h33); idle(2); word(8'h44);
      idle(5);
      check("t2_hold_coef", coef_flat, reset_bank);
      check("t2_wait_busy", FLAT_W'(cfg_busy), FLAT_W'(1));
      step(0, 0, 0, 0, 0, 1);
      check("t2_coef", coef_flat, bank_a);
      check("t2_tap", FLAT_W'(tap_num), FLAT_W'(3));
      check("t2_done", FLAT_W'(cfg_done), FLAT_W'(1));
      idle(1);
      check("t2_done_off", FLAT_W'(cfg_done), '0);

      // Abort together with valid mid-load
      step(1, 4'd15, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) word(8'(8'h80 + i));
      step(0, 0, 1, 8'h99, 1, 0);
      check("t3_err", FLAT_W'(cfg_err), FLAT_W'(1));
      check("t3_busy", FLAT_W'(cfg_busy), '0);
      check("t3_coef", coef_flat, bank_a);
      idle(2);

      // 1-tap load, abort racing swap_ok
      step(1, 4'd0, 0, 0, 0, 0);
      word(8'h7F);
      step(0, 0, 0, 0, 1, 1);
      check("t4_err", FLAT_W'(cfg_err), FLAT_W'(1));
      check("t4_tap", FLAT_W'(tap_num), FLAT_W'(3));
      check("t4_coef", coef_flat, bank_a);
      idle(2);

      // Restart attempt during LOAD keeps original length
      step(1, 4'd1, 0, 0, 0, 0);
      word(8'h55);
      step(1, 4'd5, 0, 0, 0, 0);
      check("t5_err", FLAT_W'(cfg_err), FLAT_W'(1));
      word(8'h66);
      check("t5_ready", FLAT_W'(cfg_if.cfg_ready), '0);
      step(0, 0, 0, 0, 0, 1);
      check("t5_tap", FLAT_W'(tap_num), FLAT_W'(1));
      check("t5_coef", coef_flat, bank_b);
      idle(2);

      // Full load of A5, then async reset while waiting to swap
      step(1, 4'd15, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) word(8'hA5);
      idle(1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_coef", coef_flat, reset_bank);
      check("t6_tap", FLAT_W'(tap_num), FLAT_W'(15));
      check("t6_busy", FLAT_W'(cfg_busy), '0);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 0, 0, 1);
      check("t6_no_done", FLAT_W'(cfg_done), '0);
      check("t6_coef_after", coef_flat, reset_bank);
      idle(2);

      run_cmp = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_coef_bank.md
Name: fir_coef_bank

Overview:
Parametrised, double-buffered coefficient store for the FIR datapath.
- Coefficients stream in over a valid/ready handshake into a shadow bank.
- The active bank driving the MAC array changes only on an atomic commit at a filter-safe boundary (swap_ok).
- Tap count is programmable per load session; abort and protocol-error reporting are included.
- Sits between the host configuration interface and the FIR multiply-accumulate core.

Parameters:
- COEF_W, 8, coefficient width in bits.
- MAX_TAPS, 16, number of coefficient slots; must be ≥2.
- IDX_W, $clog2(MAX_TAPS), width of tap index and length fields.
- RESET_COEF, 8'h40, reset value of every active coefficient (0.5 in Q1.7).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle pulse that opens a load session.
- cfg_len  in  IDX_W  number of taps minus 1; sampled with cfg_start.
- cfg_valid  in  1  cfg_data is valid.
- cfg_data  in  COEF_W  coefficient word.
- cfg_ready  out  1  block accepts cfg_data this cycle.
- cfg_abort  in  1  cancel the session in progress.
- swap_ok  in  1  the filter core is at a sample boundary, so a bank swap is safe.
- coef_flat  out  MAX_TAPS*COEF_W  active bank; tap i occupies bits [i*COEF_W +: COEF_W].
- tap_num  out  IDX_W  active tap count minus 1.
- cfg_busy  out  1  high whenever the FSM is not in IDLE.
- cfg_done  out  1  one-cycle pulse when a commit occurs.
- cfg_err  out  1  one-cycle pulse on abort or an illegal cfg_start.

Behaviour:
- Reset, asynchronous: every active slot = RESET_COEF; tap_num = MAX_TAPS-1; shadow slots = 0; FSM = IDLE; wr_ptr = 0; len_q = 0; cfg_ready, cfg_busy, cfg_done and cfg_err = 0.
- All outputs are registered, except that cfg_ready and cfg_busy may be decoded directly from the state register.
- FSM states: IDLE, LOAD, WAIT_SWAP.
- IDLE:
  - cfg_start=1 -> LOAD. Same edge: len_q <= cfg_len, wr_ptr <= 0, all shadow slots <= 0.
  - cfg_valid is ignored, with no error.
  - cfg_abort is ignored.
- LOAD (cfg_ready=1):
  - cfg_valid=1 writes shadow[wr_ptr] <= cfg_data, then wr_ptr++.
  - The first accepted word goes to tap 0, in ascending order.
  - A write with wr_ptr==len_q moves the FSM to WAIT_SWAP.
  - Gaps in cfg_valid are allowed and have no timeout.
- WAIT_SWAP (cfg_ready=0):
  - On an edge where swap_ok=1: every active slot <= its shadow slot, including the zero-filled slots above len_q; tap_num <= len_q; cfg_done=1 for the next cycle; FSM -> IDLE.
  - coef_flat and tap_num update on that same edge, so the new bank is visible in the cycle after swap_ok is sampled.
- cfg_abort in LOAD or WAIT_SWAP: FSM -> IDLE, cfg_err pulses one cycle, the active bank and tap_num stay unchanged, and the shadow is left stale.
- cfg_start in LOAD or WAIT_SWAP: ignored, cfg_err pulses, and the session continues.
- Simultaneous events:
  - abort with valid: abort wins, no write.
  - abort with swap_ok: abort wins, no commit.
  - abort with cfg_start while not IDLE: a single cfg_err pulse, FSM -> IDLE.
- cfg_len=0 gives a 1-tap load; cfg_len=MAX_TAPS-1 fills every slot.
- wr_ptr never exceeds len_q, so there is no wrap-around.
- The active bank is never partially updated; between commits coef_flat is constant.
- Reset asserted mid-session restores the reset values immediately and discards the session.

Test Plan:
1. Reset, then check state with no stimulus -> coef_flat = 16×8'h40, tap_num=15, cfg_busy=0, cfg_ready=0.
2. cfg_start with cfg_len=3, then words 8'h11, 8'h22, 8'h33, 8'h44 with valid gaps, swap_ok held 0 for 5 cycles -> coef_flat unchanged while waiting. Raise swap_ok -> next cycle taps 0..3 = 11,22,33,44, taps 4..15 = 0, tap_num=3, cfg_done pulses once.
3. cfg_start with cfg_len=15, write 8 words, then cfg_abort asserted together with cfg_valid -> cfg_err pulses, no write occurs, active bank equals the previous contents, FSM returns to IDLE.
4. cfg_start with cfg_len=0, one word 8'h7F, then cfg_abort and swap_ok in the same cycle -> no commit, cfg_err=1, tap_num unchanged.
5. A second cfg_start during LOAD -> cfg_err pulses and len_q is unchanged; completing the original session commits the original length.
6. rst_n asserted low in WAIT_SWAP after a full load of 8'hA5 -> coef_flat returns to 16×8'h40 and tap_num=15 asynchronously; a later swap_ok causes no commit.
